// File: rtl/session_link.sv
// session_link: bidirectional framed word transport between session endpoints A and B.
// Each direction has a TX FIFO feeding a byte serializer. A deserializer at the far end
// rebuilds the word and presents it under a valid/busy handshake.

// ---------------------------------------------------------------------------
// Transmit side: word FIFO plus header/payload serializer.
//
// state  | meaning
// IDLE   | no frame in progress; waits for a word and a free far receiver
// HDR    | driving header byte {seq, cmd}
// PAY    | driving payload bytes, MSB first, cnt counts down to the last byte
// ---------------------------------------------------------------------------
module session_link_tx #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               cmd,
    input  logic [DATA_W-1:0]        data,
    input  logic                     valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     far_free,
    output logic [7:0]               link_byte,
    output logic                     link_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int N  = DATA_W / 8;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} tx_state_t;

    logic [DATA_W+1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    tx_state_t         state;
    tx_state_t         state_next;
    logic [5:0]        seq;
    logic [1:0]        cmd_q;
    logic [DATA_W-1:0] shift_q;
    logic [CW-1:0]     cnt;

    assign busy  = (count == (AW+1)'(DEPTH));
    assign level = count;
    assign push  = valid && !busy;
    assign pop   = (state == S_IDLE) && (count != '0) && far_free;

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd, data};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Serializer next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pop) state_next = S_HDR;
            S_HDR:   state_next = S_PAY;
            S_PAY:   if (cnt == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Serializer link outputs; the link is all-zero whenever no frame is on it
    always_comb begin
        link_valid = 1'b0;
        link_byte  = 8'h00;
        case (state)
            S_HDR: begin
                link_valid = 1'b1;
                link_byte  = {seq, cmd_q};
            end
            S_PAY: begin
                link_valid = 1'b1;
                link_byte  = shift_q[DATA_W-1 -: 8];
            end
            default: begin
                link_valid = 1'b0;
                link_byte  = 8'h00;
            end
        endcase
    end

    // Serializer datapath: capture head word, shift payload, advance sequence number
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq     <= '0;
            cmd_q   <= '0;
            shift_q <= '0;
            cnt     <= '0;
        end else begin
            if (pop) begin
                {cmd_q, shift_q} <= mem[rd_ptr];
            end
            if (state == S_HDR) begin
                cnt <= CW'(N - 1);
            end
            if (state == S_PAY) begin
                shift_q <= shift_q << 8;
                cnt     <= cnt - 1'b1;
                if (cnt == '0) begin
                    seq <= seq + 1'b1;
                end
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Receive side: frame deserializer plus held output register.
//
// state    | meaning
// WAIT_HDR | next link byte is a header carrying {seq, cmd}
// COLLECT  | shifting payload bytes in, cnt counts down to the last byte
// ---------------------------------------------------------------------------
module session_link_rx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        link_byte,
    input  logic              link_valid,
    input  logic              busy,
    output logic [1:0]        cmd,
    output logic [DATA_W-1:0] data,
    output logic [5:0]        seq,
    output logic              valid
);
    localparam int N  = DATA_W / 8;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {D_WAIT_HDR, D_COLLECT} rx_state_t;

    rx_state_t         state;
    rx_state_t         state_next;
    logic [1:0]        hdr_cmd;
    logic [5:0]        hdr_seq;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_next;
    logic [CW-1:0]     cnt;
    logic              load;

    assign asm_next = (asm_q << 8) | DATA_W'(link_byte);

    // Deserializer state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= D_WAIT_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Deserializer next-state decode
    always_comb begin
        state_next = state;
        case (state)
            D_WAIT_HDR: if (link_valid) state_next = D_COLLECT;
            D_COLLECT:  if (link_valid && cnt == '0) state_next = D_WAIT_HDR;
            default:    state_next = D_WAIT_HDR;
        endcase
    end

    // Deserializer output decode: strobe when the final payload byte arrives
    always_comb begin
        load = 1'b0;
        case (state)
            D_COLLECT: load = link_valid && (cnt == '0);
            default:   load = 1'b0;
        endcase
    end

    // Header capture, payload assembly and output register with valid/busy handoff.
    // The far serializer only starts a frame once this register is free, so load
    // and a pending word never collide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hdr_cmd <= '0;
            hdr_seq <= '0;
            asm_q   <= '0;
            cnt     <= '0;
            cmd     <= '0;
            data    <= '0;
            seq     <= '0;
            valid   <= 1'b0;
        end else begin
            if (state == D_WAIT_HDR && link_valid) begin
                hdr_cmd <= link_byte[1:0];
                hdr_seq <= link_byte[7:2];
                cnt     <= CW'(N - 1);
            end
            if (state == D_COLLECT && link_valid) begin
                asm_q <= asm_next;
                cnt   <= cnt - 1'b1;
            end
            if (load) begin
                cmd   <= hdr_cmd;
                seq   <= hdr_seq;
                data  <= asm_next;
                valid <= 1'b1;
            end else if (valid && !busy) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Top: two transmit/receive pairs, cross-wired normally or self-looped.
// ---------------------------------------------------------------------------
module session_link #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int LOOPBACK = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               a_cmd,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     a_valid,
    output logic                     a_busy,
    output logic [$clog2(DEPTH):0]   a_level,
    input  logic [1:0]               b_cmd,
    input  logic [DATA_W-1:0]        b_data,
    input  logic                     b_valid,
    output logic                     b_busy,
    output logic [$clog2(DEPTH):0]   b_level,
    output logic [1:0]               a_rx_cmd,
    output logic [DATA_W-1:0]        a_rx_data,
    output logic [5:0]               a_rx_seq,
    output logic                     a_rx_valid,
    input  logic                     a_rx_busy,
    output logic [1:0]               b_rx_cmd,
    output logic [DATA_W-1:0]        b_rx_data,
    output logic [5:0]               b_rx_seq,
    output logic                     b_rx_valid,
    input  logic                     b_rx_busy,
    output logic [7:0]               link_ab_byte,
    output logic                     link_ab_valid,
    output logic [7:0]               link_ba_byte,
    output logic                     link_ba_valid
);
    logic       a_rx_free;
    logic       b_rx_free;
    logic       tx_a_far_free;
    logic       tx_b_far_free;
    logic [7:0] rx_a_byte;
    logic       rx_a_link_valid;
    logic [7:0] rx_b_byte;
    logic       rx_b_link_valid;

    // A receiver counts as free on the edge that hands its word off, which lets
    // back-to-back frames run at one per N+2 cycles.
    assign a_rx_free = !a_rx_valid || !a_rx_busy;
    assign b_rx_free = !b_rx_valid || !b_rx_busy;

    if (LOOPBACK != 0) begin : g_loop
        assign rx_a_byte       = link_ab_byte;
        assign rx_a_link_valid = link_ab_valid;
        assign rx_b_byte       = link_ba_byte;
        assign rx_b_link_valid = link_ba_valid;
        assign tx_a_far_free   = a_rx_free;
        assign tx_b_far_free   = b_rx_free;
    end else begin : g_cross
        assign rx_a_byte       = link_ba_byte;
        assign rx_a_link_valid = link_ba_valid;
        assign rx_b_byte       = link_ab_byte;
        assign rx_b_link_valid = link_ab_valid;
        assign tx_a_far_free   = b_rx_free;
        assign tx_b_far_free   = a_rx_free;
    end

    session_link_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_a (
        .clk        (clk),
        .reset      (reset),
        .cmd        (a_cmd),
        .data       (a_data),
        .valid      (a_valid),
        .busy       (a_busy),
        .level      (a_level),
        .far_free   (tx_a_far_free),
        .link_byte  (link_ab_byte),
        .link_valid (link_ab_valid)
    );

    session_link_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_b (
        .clk        (clk),
        .reset      (reset),
        .cmd        (b_cmd),
        .data       (b_data),
        .valid      (b_valid),
        .busy       (b_busy),
        .level      (b_level),
        .far_free   (tx_b_far_free),
        .link_byte  (link_ba_byte),
        .link_valid (link_ba_valid)
    );

    session_link_rx #(.DATA_W(DATA_W)) u_rx_a (
        .clk        (clk),
        .reset      (reset),
        .link_byte  (rx_a_byte),
        .link_valid (rx_a_link_valid),
        .busy       (a_rx_busy),
        .cmd        (a_rx_cmd),
        .data       (a_rx_data),
        .seq        (a_rx_seq),
        .valid      (a_rx_valid)
    );

    session_link_rx #(.DATA_W(DATA_W)) u_rx_b (
        .clk        (clk),
        .reset      (reset),
        .link_byte  (rx_b_byte),
        .link_valid (rx_b_link_valid),
        .busy       (b_rx_busy),
        .cmd        (b_rx_cmd),
        .data       (b_rx_data),
        .seq        (b_rx_seq),
        .valid      (b_rx_valid)
    );
endmodule
